// File: rtl/fp_deco_pipe_pkg.sv
// Shared floating-point decode definitions: default field widths, class bit
// positions and the width of one decoded-operand record.
package fp_deco_pipe_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  // One-hot class vector {nan, inf, denorm, zero}; all-zero means normal
  localparam int unsigned CLS_W      = 4;
  localparam int unsigned CLS_ZERO   = 0;
  localparam int unsigned CLS_DENORM = 1;
  localparam int unsigned CLS_INF    = 2;
  localparam int unsigned CLS_NAN    = 3;

  // Decoded operand record: {sign, effective exponent, {hidden, fraction}, class}
  function automatic int unsigned deco_rec_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + (man_w + 1) + CLS_W;
  endfunction

endpackage

// File: rtl/fp_deco_unit.sv
// Combinational decode of one packed operand into sign, effective exponent,
// mantissa with hidden bit, and one-hot class.
module fp_deco_unit
  import fp_deco_pipe_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_c,
  output logic [EXP_W-1:0]     exp_c,
  output logic [MAN_W:0]       man_c,
  output logic [CLS_W-1:0]     cls_c
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic [EXP_W-1:0] field;
  logic [MAN_W-1:0] frac;
  logic             e_zero;
  logic             e_ones;
  logic             f_zero;

  assign field  = op_i[W-2 -: EXP_W];
  assign frac   = op_i[MAN_W-1:0];
  assign e_zero = (field == '0);
  assign e_ones = &field;
  assign f_zero = (frac == '0);

  assign sign_c = op_i[W-1];
  // Denormals and zero share the minimum normal exponent
  assign exp_c  = e_zero ? EXP_W'(1) : field;
  assign man_c  = {!e_zero, frac};

  always_comb begin
    cls_c             = '0;
    cls_c[CLS_NAN]    = e_ones && !f_zero;
    cls_c[CLS_INF]    = e_ones && f_zero;
    cls_c[CLS_DENORM] = e_zero && !f_zero;
    cls_c[CLS_ZERO]   = e_zero && f_zero;
  end

endmodule

// File: rtl/fp_deco_pipe.sv
// Decodes an operand pair, computes magnitude ordering and exponent distance,
// and delivers it through a one-entry skid buffer with valid/ready handshakes.
module fp_deco_pipe
  import fp_deco_pipe_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] Float_num_A,
  input  logic [EXP_W+MAN_W:0] Float_num_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 Signo_A,
  output logic                 Signo_B,
  output logic [EXP_W-1:0]     Exponente_A,
  output logic [EXP_W-1:0]     Exponente_B,
  output logic [MAN_W:0]       Mantissa_A,
  output logic [MAN_W:0]       Mantissa_B,
  output logic [CLS_W-1:0]     Class_A,
  output logic [CLS_W-1:0]     Class_B,
  output logic [EXP_W-1:0]     Exp_diff,
  output logic                 Swap
);

  localparam int unsigned OP_W   = deco_rec_w(EXP_W, MAN_W);
  localparam int unsigned PAIR_W = 2 * OP_W + EXP_W + 1;

  logic              sign_a_c, sign_b_c;
  logic [EXP_W-1:0]  exp_a_c, exp_b_c;
  logic [MAN_W:0]    man_a_c, man_b_c;
  logic [CLS_W-1:0]  cls_a_c, cls_b_c;
  logic [EXP_W-1:0]  exp_diff_c;
  logic              swap_c;
  logic [PAIR_W-1:0] new_pair_c;

  logic              out_valid_q, out_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [PAIR_W-1:0] out_q, out_d;
  logic [PAIR_W-1:0] skid_q, skid_d;
  logic              take_in;
  logic              drain;

  fp_deco_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_deco_a (
    .op_i   (Float_num_A),
    .sign_c (sign_a_c),
    .exp_c  (exp_a_c),
    .man_c  (man_a_c),
    .cls_c  (cls_a_c)
  );

  fp_deco_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_deco_b (
    .op_i   (Float_num_B),
    .sign_c (sign_b_c),
    .exp_c  (exp_b_c),
    .man_c  (man_b_c),
    .cls_c  (cls_b_c)
  );

  // Magnitude order and exponent distance, evaluated for every class
  assign swap_c     = {exp_b_c, man_b_c} > {exp_a_c, man_a_c};
  assign exp_diff_c = (exp_a_c >= exp_b_c) ? (exp_a_c - exp_b_c) : (exp_b_c - exp_a_c);
  assign new_pair_c = {sign_a_c, exp_a_c, man_a_c, cls_a_c,
                       sign_b_c, exp_b_c, man_b_c, cls_b_c,
                       exp_diff_c, swap_c};

  assign take_in = in_valid && in_ready_q;
  assign drain   = out_valid_q && out_ready;

  // Skid is only ever occupied while the output register is full and stalled
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (take_in) begin
      if (!out_valid_q || drain) begin
        out_d       = new_pair_c;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = new_pair_c;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign {Signo_A, Exponente_A, Mantissa_A, Class_A,
          Signo_B, Exponente_B, Mantissa_B, Class_B,
          Exp_diff, Swap} = out_q;

endmodule

// File: tb/tb_fp_deco_pipe.sv
// Bench for fp_deco_pipe: a queue-based model of the two-entry buffer with
// arithmetic decoding, checked every cycle, plus directed literal expectations.
module tb_fp_deco_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Float_num_A = '0;
  logic [31:0] Float_num_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        Signo_A, Signo_B;
  logic [7:0]  Exponente_A, Exponente_B;
  logic [23:0] Mantissa_A, Mantissa_B;
  logic [3:0]  Class_A, Class_B;
  logic [7:0]  Exp_diff;
  logic        Swap;

  int checks = 0;
  int errors = 0;
  bit rnd_on = 1'b0;

  fp_deco_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Float_num_A (Float_num_A),
    .Float_num_B (Float_num_B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Signo_A     (Signo_A),
    .Signo_B     (Signo_B),
    .Exponente_A (Exponente_A),
    .Exponente_B (Exponente_B),
    .Mantissa_A  (Mantissa_A),
    .Mantissa_B  (Mantissa_B),
    .Class_A     (Class_A),
    .Class_B     (Class_B),
    .Exp_diff    (Exp_diff),
    .Swap        (Swap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [3:0]  ca, cb;
    logic [7:0]  ed;
    logic        sw;
  } exp_t;

  exp_t model_q[$];
  bit   model_ready = 1'b0;

  function automatic int eff_exp(input logic [31:0] x);
    int e = int'(x[30:23]);
    return (e == 0) ? 1 : e;
  endfunction

  function automatic logic [3:0] klass(input logic [31:0] x);
    int e = int'(x[30:23]);
    int f = int'(x[22:0]);
    if (e == 255) return (f != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (f != 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  function automatic exp_t model_dec(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint mag_a, mag_b;
    int ea = eff_exp(a);
    int eb = eff_exp(b);
    int ma = int'(a[22:0]) + ((a[30:23] != 8'd0) ? (1 << 23) : 0);
    int mb = int'(b[22:0]) + ((b[30:23] != 8'd0) ? (1 << 23) : 0);
    mag_a = longint'(ea) * 64'd16777216 + longint'(ma);
    mag_b = longint'(eb) * 64'd16777216 + longint'(mb);
    r.sa = a[31];
    r.sb = b[31];
    r.ea = 8'(ea);
    r.eb = 8'(eb);
    r.ma = 24'(ma);
    r.mb = 24'(mb);
    r.ca = klass(a);
    r.cb = klass(b);
    r.ed = 8'((ea > eb) ? ea - eb : eb - ea);
    r.sw = mag_b > mag_a;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Model: occupancy tracked as a queue; ready means fewer than two pairs held
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      model_ready = 1'b0;
    end else begin
      bit acc;
      acc = in_valid && model_ready;
      if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
      if (acc) model_q.push_back(model_dec(Float_num_A, Float_num_B));
      model_ready = (model_q.size() < 2);
    end
  end

  // Per-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_data", {Exponente_A, Exponente_B, Exp_diff, 7'd0, Swap},
          32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(model_ready));
      chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      if (out_valid && model_q.size() > 0) begin
        chk("Signo_A", 32'(Signo_A), 32'(model_q[0].sa));
        chk("Signo_B", 32'(Signo_B), 32'(model_q[0].sb));
        chk("Exponente_A", 32'(Exponente_A), 32'(model_q[0].ea));
        chk("Exponente_B", 32'(Exponente_B), 32'(model_q[0].eb));
        chk("Mantissa_A", 32'(Mantissa_A), 32'(model_q[0].ma));
        chk("Mantissa_B", 32'(Mantissa_B), 32'(model_q[0].mb));
        chk("Class_A", 32'(Class_A), 32'(model_q[0].ca));
        chk("Class_B", 32'(Class_B), 32'(model_q[0].cb));
        chk("Exp_diff", 32'(Exp_diff), 32'(model_q[0].ed));
        chk("Swap", 32'(Swap), 32'(model_q[0].sw));
      end
    end
  end

  // Random backpressure during the random phase
  always @(posedge clk) begin
    if (rnd_on) begin
      #1 out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Present a pair and hold it until accepted; returns just after the accepting edge
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bit r;
    bit done = 1'b0;
    in_valid    = 1'b1;
    Float_num_A = a;
    Float_num_B = b;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      done = r;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    push(32'h3F800000, 32'h3F800000);
    @(negedge clk);
    chk("one_out_valid", 32'(out_valid), 32'd1);
    chk("one_exp", 32'(Exponente_A), 32'h7F);
    chk("one_man", 32'(Mantissa_A), 32'h800000);
    chk("one_cls", 32'(Class_A), 32'h0);
    chk("one_diff_swap", {Exp_diff, 7'd0, Swap}, 32'h0);

    @(posedge clk); #1;
    push(32'h00000001, 32'h00000000);
    @(negedge clk);
    chk("den_exp_a", 32'(Exponente_A), 32'h01);
    chk("den_man_a", 32'(Mantissa_A), 32'h000001);
    chk("den_cls_a", 32'(Class_A), 32'b0010);
    chk("zero_cls_b", 32'(Class_B), 32'b0001);
    chk("zero_man_b", 32'(Mantissa_B), 32'h0);
    chk("den_swap", 32'(Swap), 32'd0);

    @(posedge clk); #1;
    push(32'h7F800000, 32'h7FC00000);
    @(negedge clk);
    chk("inf_cls_a", 32'(Class_A), 32'b0100);
    chk("nan_cls_b", 32'(Class_B), 32'b1000);
    chk("nan_man_b", 32'(Mantissa_B), 32'hC00000);

    @(posedge clk); #1;
    push(32'h3F800000, 32'h40400000);
    @(negedge clk);
    chk("ord_diff", 32'(Exp_diff), 32'd1);
    chk("ord_swap", 32'(Swap), 32'd1);
    @(posedge clk); #1;
    push(32'h40400000, 32'h3F800000);
    @(negedge clk);
    chk("rev_diff", 32'(Exp_diff), 32'd1);
    chk("rev_swap", 32'(Swap), 32'd0);

    // Equal effective exponents: ordering decided by mantissa, and signs ignored
    @(posedge clk); #1;
    push(32'h80800000, 32'h00400000);
    @(negedge clk);
    chk("mix_swap", 32'(Swap), 32'd0);
    chk("mix_sign", {31'd0, Signo_A}, 32'd1);
    @(posedge clk); #1;
    push(32'h3FC00000, 32'hBFE00000);
    @(negedge clk);
    chk("man_swap", 32'(Swap), 32'd1);

    // Backpressure: two pairs fill the buffer, the third waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(32'h3F800000, 32'h00000000);
    push(32'h40000000, 32'h00000000);
    in_valid    = 1'b1;
    Float_num_A = 32'h40800000;
    Float_num_B = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_exp", 32'(Exponente_A), 32'h7F);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'h40800000, 32'h00000000);
    repeat (4) @(posedge clk);
    #1;

    // Reset with the skid full
    out_ready = 1'b0;
    push(32'h41000000, 32'h3F800000);
    push(32'h41800000, 32'h3F800000);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_wait", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);

    // Random pairs with random backpressure, biased toward special exponents
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a[30:23] = 8'h00;
      if (i % 4 == 1) b[30:23] = 8'hFF;
      if (i % 4 == 2) b[30:23] = a[30:23];
      if (i % 8 == 3) a[22:0] = 23'd0;
      push(a, b);
    end
    rnd_on = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_drained", 32'(model_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_deco_pipe.md
FP_DECO_PIPE -- requirements
Module: fp_deco_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits.
REQ-002 Parameter MAN_W, default 23, stored fraction width in bits; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair on Float_num_A/Float_num_B is valid.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 Float_num_A, Float_num_B  input  W each  packed IEEE-754-style operands.
REQ-008 out_valid  output  1  decoded pair valid.
REQ-009 out_ready  input  1  downstream accepts the pair this cycle.
REQ-010 Signo_A/B  output  1 each  sign bits.
REQ-011 Exponente_A/B  output  EXP_W each  effective exponent: raw field, or 1 when the field is 0 (denormal/zero).
REQ-012 Mantissa_A/B  output  MAN_W+1 each  {hidden bit, fraction}; hidden bit = (exponent field != 0).
REQ-013 Class_A/B  output  4 each  one-hot {nan, inf, denorm, zero}; all-zero means normal.
REQ-014 Exp_diff  output  EXP_W  |Exponente_A - Exponente_B|.
REQ-015 Swap  output  1  1 when |B| > |A| by {effective exponent, mantissa}; 0 on equality.

Function
REQ-016 A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
REQ-017 Decoding is combinational on the inputs and captured into the output register; latency is 1 cycle from input transfer to out_valid.
REQ-018 Storage is an output register plus one skid register (capacity 2 pairs); order is strictly FIFO.
REQ-019 in_ready is a registered signal equal to NOT skid_full; it does not depend combinationally on out_ready.
REQ-020 Output empty: an accepted pair loads the output register directly.
REQ-021 Output full and draining in the same cycle: an accepted pair loads the output register; no skid use.
REQ-022 Output full and not draining: an accepted pair loads the skid register; in_ready deasserts next cycle.
REQ-023 Skid full and output drains: the skid moves into the output register, skid clears, and in_ready reasserts next cycle.
REQ-024 While out_valid && !out_ready, all outputs stay bit-stable.
REQ-025 Classification: exponent field all ones with fraction != 0 -> nan; all ones with fraction 0 -> inf; field 0 with fraction != 0 -> denorm; field 0 with fraction 0 -> zero.
REQ-026 Exp_diff uses effective exponents and is computed at full EXP_W with no wrap (subtract the smaller from the larger).
REQ-027 Swap and Exp_diff are computed for all classes, including nan/inf; consumers gate on Class.

Reset
REQ-028 While rst is high: out_valid=0, in_ready=0, skid empty; data outputs are 0.
REQ-029 in_ready rises on the first clk edge after rst falls.
REQ-030 Reset mid-operation discards both stored pairs; no partial transfer completes.

Structure
REQ-031 Class bit indices, EXP_W/MAN_W defaults, and the decoded-operand record width belong in a shared fp package.
REQ-032 Single-operand decoding (sign, effective exponent, mantissa, class) is one sub-module, fp_deco_unit, instantiated twice.
REQ-033 Compare and difference logic, the skid buffer, and the handshake reside in fp_deco_pipe; target 150-300 lines of RTL.

Verification
REQ-034 A=0x3F800000, B=0x3F800000, out_ready=1 -> one cycle later: Exponente=0x7F, Mantissa=0x800000, Class=0000, Exp_diff=0, Swap=0.
REQ-035 A=0x00000001, B=0x00000000 -> A: Exponente=0x01, Mantissa=0x000001, Class=denorm; B: Class=zero, Mantissa=0; Swap=0.
REQ-036 A=0x7F800000, B=0x7FC00000 -> Class_A=inf, Class_B=nan, Mantissa_B=0xC00000.
REQ-037 A=0x3F800000, B=0x40400000 -> Exp_diff=1, Swap=1; swapping the operands gives Exp_diff=1, Swap=0.
REQ-038 out_ready=0 with 3 back-to-back in_valid pairs -> 2 pairs accepted, in_ready=0 after the second; outputs stable; raising out_ready drains them in order, and the third pair is then accepted.
REQ-039 Assert rst while the skid is full -> out_valid=0 immediately; in_ready=1 one cycle after release; no stale pair is ever emitted.
